// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared register-bank widths and writeback requester indices
package rf_ctrl_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int DATA_W = 32;
  localparam int NUM_REQ = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LINK = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant searching upward from ptr
module rr_arbiter #(
  parameter int N = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);
  int c;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    c = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        grant[c] = 1'b1;
        idx = PW'(c);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates the bank write port and tracks in-flight writes for hazard stalls
module regfile_wb_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REQ = rf_ctrl_pkg::NUM_REQ,
  parameter int DATA_W = rf_ctrl_pkg::DATA_W,
  parameter int REG_ADDR_W = rf_ctrl_pkg::REG_ADDR_W,
  parameter int NUM_REGS = rf_ctrl_pkg::NUM_REGS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [REG_ADDR_W-1:0]         destination,
  output logic [DATA_W-1:0]             ldr_mux_in,
  output logic                          reg_write,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_dest,
  input  logic [REG_ADDR_W-1:0]         src1_sel,
  input  logic [REG_ADDR_W-1:0]         src2_sel,
  output logic                          issue_stall,
  output logic [NUM_REGS-1:0]           pending
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] rr_ptr, win, ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic any;
  logic [REG_ADDR_W-1:0] wd;
  logic [DATA_W-1:0] wdat;
  logic [NUM_REGS-1:0] set_m, clr_m;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(win)
  );
  assign any = |grant;
  assign req_ready = rst ? '0 : grant;
  assign ptr_nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  always_comb begin
    wd = '0;
    wdat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        wd = req_dest[i*REG_ADDR_W +: REG_ADDR_W];
        wdat = req_data[i*DATA_W +: DATA_W];
      end
    end
  end
  assign issue_stall = issue_valid & (pending[src1_sel] | pending[src2_sel] | pending[issue_dest]);
  assign set_m = (issue_valid && !issue_stall) ? NUM_REGS'(1) << issue_dest : '0;
  assign clr_m = reg_write ? NUM_REGS'(1) << destination : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      destination <= '0;
      ldr_mux_in <= '0;
      reg_write <= 1'b0;
      rr_ptr <= '0;
      pending <= '0;
    end else begin
      reg_write <= any;
      if (any) begin
        destination <= wd;
        ldr_mux_in <= wdat;
        rr_ptr <= ptr_nxt;
      end
      pending <= (pending & ~clr_m) | set_m;
    end
  end
endmodule
